// File: rtl/pipeline_mw_stage.sv
// pipeline_mw_stage: MEM/WB pipeline register with stall/flush, valid tracking,
// write-back result selection and saturating retired/bubble counters.
// Ports: clk/reset (sync, active-high); stall/flush from the hazard unit;
// *_m inputs from the memory stage; *_w registered outputs to write-back;
// result_w is the combinational write-back value; retired_count/bubble_count
// are the performance counters.
module pipeline_mw_stage #(
    parameter int DATA_W            = 32,
    parameter int REG_AW            = 5,
    parameter int CNT_W             = 16,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic              upper_m,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [DATA_W-1:0] read_data_m,
    input  logic [REG_AW-1:0] write_reg_m,
    output logic              valid_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic              upper_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic [REG_AW-1:0] write_reg_w,
    output logic [DATA_W-1:0] result_w,
    output logic [CNT_W-1:0]  retired_count,
    output logic [CNT_W-1:0]  bubble_count
);
    localparam int HALF = DATA_W / 2;

    logic              valid_q, valid_d;
    logic              rw_q, rw_d;
    logic              m2r_q, m2r_d;
    logic              up_q, up_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] wr_q, wr_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [CNT_W-1:0]  bub_q, bub_d;
    logic              zero_dst;
    logic [CNT_W-1:0]  ret_inc, bub_inc;

    // Writes to register 0 are architecturally discarded when suppression is on
    assign zero_dst = (ZERO_REG_SUPPRESS != 0) && (write_reg_m == '0);
    assign ret_inc  = (ret_q == '1) ? ret_q : ret_q + 1'b1;
    assign bub_inc  = (bub_q == '1) ? bub_q : bub_q + 1'b1;

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        m2r_d   = m2r_q;
        up_d    = up_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ret_d   = ret_q;
        bub_d   = bub_q;
        if (flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            m2r_d   = 1'b0;
            up_d    = 1'b0;
            alu_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            bub_d   = bub_inc;
        end else if (!stall) begin
            valid_d = valid_m;
            rw_d    = reg_write_m & valid_m & ~zero_dst;
            m2r_d   = mem_to_reg_m & valid_m;
            up_d    = upper_m & valid_m;
            alu_d   = alu_result_m;
            rd_d    = read_data_m;
            wr_d    = write_reg_m;
            ret_d   = valid_m ? ret_inc : ret_q;
            bub_d   = valid_m ? bub_q : bub_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            up_q    <= 1'b0;
            alu_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ret_q   <= '0;
            bub_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            up_q    <= up_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ret_q   <= ret_d;
            bub_q   <= bub_d;
        end
    end

    assign valid_w       = valid_q;
    assign reg_write_w   = rw_q;
    assign mem_to_reg_w  = m2r_q;
    assign upper_w       = up_q;
    assign alu_result_w  = alu_q;
    assign read_data_w   = rd_q;
    assign write_reg_w   = wr_q;
    assign retired_count = ret_q;
    assign bubble_count  = bub_q;

    // Memory data has precedence over the upper-immediate path
    assign result_w = m2r_q ? rd_q : up_q ? {alu_q[HALF-1:0], {HALF{1'b0}}} : alu_q;
endmodule

// File: tb/tb_pipeline_mw_stage.sv
// tb_pipeline_mw_stage: directed vector bench for pipeline_mw_stage
module tb_pipeline_mw_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_m, reg_write_m, mem_to_reg_m, upper_m;
    logic [31:0] alu_result_m, read_data_m;
    logic [4:0]  write_reg_m;

    logic        valid_w, reg_write_w, mem_to_reg_w, upper_w;
    logic [31:0] alu_result_w, read_data_w, result_w;
    logic [4:0]  write_reg_w;
    logic [15:0] retired_count, bubble_count;

    logic        s_valid_w, s_reg_write_w, s_mem_to_reg_w, s_upper_w;
    logic [31:0] s_alu_result_w, s_read_data_w, s_result_w;
    logic [4:0]  s_write_reg_w;
    logic [2:0]  s_retired_count, s_bubble_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_mw_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .upper_m(upper_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .write_reg_m(write_reg_m), .valid_w(valid_w), .reg_write_w(reg_write_w),
        .mem_to_reg_w(mem_to_reg_w), .upper_w(upper_w), .alu_result_w(alu_result_w),
        .read_data_w(read_data_w), .write_reg_w(write_reg_w), .result_w(result_w),
        .retired_count(retired_count), .bubble_count(bubble_count)
    );

    pipeline_mw_stage #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .upper_m(upper_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .write_reg_m(write_reg_m), .valid_w(s_valid_w), .reg_write_w(s_reg_write_w),
        .mem_to_reg_w(s_mem_to_reg_w), .upper_w(s_upper_w), .alu_result_w(s_alu_result_w),
        .read_data_w(s_read_data_w), .write_reg_w(s_write_reg_w), .result_w(s_result_w),
        .retired_count(s_retired_count), .bubble_count(s_bubble_count)
    );

    typedef struct {
        logic        r, s, f, v, rw, m2r, up;
        logic [31:0] alu, rd;
        logic [4:0]  wr;
        logic        ev, erw, em2r, eup;
        logic [31:0] eres;
        logic [4:0]  ewr;
        logic [15:0] eret, ebub;
    } vec_t;

    function automatic vec_t mk(input logic r, s, f, v, rw, m2r, up,
                                input logic [31:0] alu, rd, input logic [4:0] wr,
                                input logic ev, erw, em2r, eup, input logic [31:0] eres,
                                input logic [4:0] ewr, input logic [15:0] eret, ebub);
        vec_t t;
        t.r = r; t.s = s; t.f = f; t.v = v; t.rw = rw; t.m2r = m2r; t.up = up;
        t.alu = alu; t.rd = rd; t.wr = wr;
        t.ev = ev; t.erw = erw; t.em2r = em2r; t.eup = eup;
        t.eres = eres; t.ewr = ewr; t.eret = eret; t.ebub = ebub;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, f, v, rw, m2r, up,
                         input logic [31:0] alu, rd, input logic [4:0] wr);
        reset = r; stall = s; flush = f; valid_m = v; reg_write_m = rw;
        mem_to_reg_m = m2r; upper_m = up; alu_result_m = alu; read_data_m = rd;
        write_reg_m = wr;
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = mk(1,1,0,1,1,1,1, $urandom, $urandom, 5'($urandom), 0,0,0,0, 32'h0, 5'd0, 0, 0);
        tbl[1]  = mk(1,0,1,1,1,0,1, $urandom, $urandom, 5'($urandom), 0,0,0,0, 32'h0, 5'd0, 0, 0);
        tbl[2]  = mk(0,0,0,1,1,0,0, 32'h0000_1234, 32'h0, 5'd5, 1,1,0,0, 32'h0000_1234, 5'd5, 1, 0);
        tbl[3]  = mk(0,0,0,1,1,1,0, 32'h1, 32'hDEAD_BEEF, 5'd3, 1,1,1,0, 32'hDEAD_BEEF, 5'd3, 2, 0);
        tbl[4]  = mk(0,0,0,1,1,0,1, 32'h0000_ABCD, 32'hFFFF_FFFF, 5'd4, 1,1,0,1, 32'hABCD_0000, 5'd4, 3, 0);
        tbl[5]  = mk(0,0,0,1,1,0,0, 32'h77, 32'h0, 5'd7, 1,1,0,0, 32'h77, 5'd7, 4, 0);
        tbl[6]  = mk(0,1,0,0,0,1,1, 32'h99, 32'h99, 5'd9, 1,1,0,0, 32'h77, 5'd7, 4, 0);
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = mk(0,1,1,1,1,1,1, 32'h88, 32'h88, 5'd8, 0,0,0,0, 32'h0, 5'd0, 4, 1);
        tbl[10] = mk(0,0,0,0,1,0,0, 32'h66, 32'h0, 5'd6, 0,0,0,0, 32'h66, 5'd6, 4, 2);
        tbl[11] = mk(0,0,0,1,1,0,0, 32'h55, 32'h0, 5'd0, 1,0,0,0, 32'h55, 5'd0, 5, 2);
        tbl[12] = mk(0,0,0,1,1,1,1, 32'h1234_5678, 32'hCAFE_F00D, 5'd2, 1,1,1,1, 32'hCAFE_F00D, 5'd2, 6, 2);
        tbl[13] = mk(0,0,0,0,1,1,1, 32'h0000_2222, 32'h1111_1111, 5'd1, 0,0,0,0, 32'h0000_2222, 5'd1, 6, 3);
        tbl[14] = mk(0,0,1,0,0,0,0, 32'h3, 32'h0, 5'd0, 0,0,0,0, 32'h0, 5'd0, 6, 4);
        tbl[15] = mk(1,1,1,1,1,1,1, 32'h5, 32'h6, 5'd7, 0,0,0,0, 32'h0, 5'd0, 0, 0);
        tbl[16] = mk(0,0,0,1,1,0,1, 32'hFFFF_0001, 32'h0, 5'd31, 1,1,0,1, 32'h0001_0000, 5'd31, 1, 0);

        drive(1,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].rw, tbl[i].m2r,
                  tbl[i].up, tbl[i].alu, tbl[i].rd, tbl[i].wr);
            @(posedge clk); #1;
            check("valid_w",       i, 32'(valid_w),       32'(tbl[i].ev));
            check("reg_write_w",   i, 32'(reg_write_w),   32'(tbl[i].erw));
            check("mem_to_reg_w",  i, 32'(mem_to_reg_w),  32'(tbl[i].em2r));
            check("upper_w",       i, 32'(upper_w),       32'(tbl[i].eup));
            check("result_w",      i, result_w,           tbl[i].eres);
            check("write_reg_w",   i, 32'(write_reg_w),   32'(tbl[i].ewr));
            check("retired_count", i, 32'(retired_count), 32'(tbl[i].eret));
            check("bubble_count",  i, 32'(bubble_count),  32'(tbl[i].ebub));
        end

        // Saturation on the 3-bit counter instance, wide instance keeps counting
        drive(1,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        check("sat_reset_ret", 0, 32'(s_retired_count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(0,0,0,1,1,0,0, 32'(i), 32'h0, 5'd1);
            @(posedge clk); #1;
            check("sat_ret",  i, 32'(s_retired_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
            check("wide_ret", i, 32'(retired_count),   32'(i + 1));
        end
        drive(0,1,0,1,1,0,0, 32'h0, 32'h0, 5'd1);
        @(posedge clk); #1;
        check("sat_ret_stall", 0, 32'(s_retired_count), 32'd7);
        for (int i = 0; i < 9; i++) begin
            drive(0,0,0,0,1,0,0, 32'h0, 32'h0, 5'd1);
            @(posedge clk); #1;
            check("sat_bub", i, 32'(s_bubble_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        check("sat_ret_hold", 0, 32'(s_retired_count), 32'd7);
        drive(1,0,0,1,1,0,0, 32'h0, 32'h0, 5'd1);
        @(posedge clk); #1;
        check("sat_ret_clear", 0, 32'(s_retired_count), 32'd0);
        check("sat_bub_clear", 0, 32'(s_bubble_count),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_mw_stage.md
Name: pipeline_mw_stage

Overview:
Parametrised MEM/WB pipeline register, the successor to the fixed 32-bit MEM/WB register. It adds synchronous reset, hazard-unit stall and flush, a valid bit per slot, and write-back result selection including the upper-immediate path. It also provides saturating performance counters for retired and bubble slots. It sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of ALU result, memory read data and write-back result
REG_AW, 5, register-file address width
CNT_W, 16, width of each performance counter
ZERO_REG_SUPPRESS, 1, 1 = force reg_write_w low when write_reg is 0

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold current W-stage contents
flush  in  1  replace W-stage slot with a bubble
valid_m  in  1  M-stage slot holds a real instruction
reg_write_m  in  1  register write enable from M
mem_to_reg_m  in  1  select memory data for write-back
upper_m  in  1  upper-immediate write-back (load-upper)
alu_result_m  in  DATA_W  ALU result from M
read_data_m  in  DATA_W  memory read data from M
write_reg_m  in  REG_AW  destination register from M
valid_w  out  1  W-stage slot valid
reg_write_w  out  1  gated register write enable
mem_to_reg_w  out  1  registered select
upper_w  out  1  registered upper flag
alu_result_w  out  DATA_W  registered ALU result
read_data_w  out  DATA_W  registered memory data
write_reg_w  out  REG_AW  registered destination
result_w  out  DATA_W  combinational write-back value
retired_count  out  CNT_W  valid slots accepted
bubble_count  out  CNT_W  invalid or flushed slots accepted

Behaviour:
- Reset: every registered output and both counters are 0 on the edge where reset=1. result_w is therefore 0 after reset.
- Priority on each rising edge: reset > flush > stall > load.
- Flush: valid_w, reg_write_w, mem_to_reg_w and upper_w go to 0. Data fields and write_reg_w also go to 0. bubble_count increments.
- Stall without flush: all registers hold. No counter changes.
- Load (no reset, flush or stall):
  - valid_w <= valid_m.
  - reg_write_w <= reg_write_m & valid_m & ~(ZERO_REG_SUPPRESS & (write_reg_m == 0)).
  - mem_to_reg_w and upper_w are ANDed with valid_m.
  - Data and address fields load unconditionally.
- Latency: one cycle from M inputs to W outputs.
- result_w is combinational from W registers only:
  - if mem_to_reg_w: read_data_w
  - else if upper_w: {alu_result_w[DATA_W/2-1:0], DATA_W/2 zeros}
  - else: alu_result_w
  - mem_to_reg_w takes precedence over upper_w.
- Counters on a load edge: retired_count+1 if the loaded valid_m=1, else bubble_count+1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Counters change only on load or flush edges, never during stall or reset.
- Flush and stall asserted together: flush wins and a bubble is counted.
- Reset mid-stall or mid-flush: reset wins and all state clears that edge.
- DATA_W must be even. Any parameter change requires no RTL edits.

Test Plan:
- Reset: reset=1 for 2 cycles with random inputs -> all outputs 0, counters 0.
- Basic load: valid_m=1, reg_write_m=1, mem_to_reg_m=0, upper_m=0, alu_result_m=0x0000_1234, write_reg_m=5 -> next edge reg_write_w=1, write_reg_w=5, result_w=0x0000_1234, retired_count=1.
- Result mux: mem_to_reg_m=1, read_data_m=0xDEAD_BEEF -> result_w=0xDEAD_BEEF. Then mem_to_reg_m=0, upper_m=1, alu_result_m=0x0000_ABCD -> result_w=0xABCD_0000.
- Stall/flush: load write_reg_m=7, then stall=1 for 3 cycles with new inputs -> write_reg_w stays 7 and counters unchanged. Then stall=1 and flush=1 together -> valid_w=0, reg_write_w=0, bubble_count=1.
- Gating: valid_m=0 with reg_write_m=1 -> reg_write_w=0 and bubble_count increments. valid_m=1, reg_write_m=1, write_reg_m=0 -> reg_write_w=0, valid_w=1.
- Saturation: CNT_W=3, 10 valid loads -> retired_count=7 and holds at 7. reset=1 -> 0.
